wshb_frame_reader: RTL and testbench

WSHB_FRAME_READER -- requirements
Module: wshb_frame_reader

---
 rtl/wshb_frame_reader.sv | 151 +++++++++++++++
 tb/tb_wshb_frame_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_frame_reader.sv
// Wishbone classic read master that walks a frame buffer in raster order.
// It delivers every pixel word, tagged with a start-of-frame flag, through a
// first-word-fall-through FIFO to a valid/ready consumer.
module wshb_frame_reader #(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    // Wishbone master
    output logic [31:0] adr,
    input  logic [31:0] dat_sm,
    output logic [31:0] dat_ms,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    // pixel stream
    output logic [31:0] pix_data,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done
);

    // state | meaning
    // IDLE  | enable low or not yet started, no bus activity
    // REQ   | Wishbone read outstanding, stb high, adr stable
    // HOLD  | one-cycle bus gap after a termination, or waiting for FIFO room
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    localparam int NPIX  = HDISP * VDISP;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [31:0]        adr_next;

    logic [31:0]        mem_data [FIFO_DEPTH];
    logic               mem_sof  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               term_ok;
    logic               term_bad;
    logic               push;
    logic               pop;
    logic               room;

    assign dat_ms = 32'h0;
    assign we     = 1'b0;
    assign sel    = 4'hF;
    assign cti    = 3'b000;
    assign bte    = 2'b00;
    assign cyc    = stb;

    // err/rty take priority over ack; both only count while a cycle is open
    assign term_bad = stb & (err | rty);
    assign term_ok  = stb & ack & ~err & ~rty;
    assign push     = term_ok;
    assign pop      = pix_valid & pix_ready;
    assign room     = (count < DEPTH_C);

    assign idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    assign adr_next = BASE_ADDR + {32'(idx_next) << 2};

    assign frame_done = term_ok & (idx == LAST_IDX);

    assign pix_valid = (count != '0);
    assign pix_data  = mem_data[rd_ptr];
    assign pix_sof   = pix_valid & mem_sof[rd_ptr];

    // Request sequencer: every termination passes through HOLD, which
    // guarantees stb drops for at least one cycle between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            stb   <= 1'b0;
            idx   <= '0;
            adr   <= BASE_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && room) begin
                        state <= REQ;
                        stb   <= 1'b1;
                    end
                end
                REQ: begin
                    if (term_ok || term_bad) begin
                        stb   <= 1'b0;
                        state <= enable ? HOLD : IDLE;
                        if (term_ok) begin
                            idx <= idx_next;
                            adr <= adr_next;
                        end
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (room) begin
                        state <= REQ;
                        stb   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    stb   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; push into a full FIFO cannot happen
    // because a request is only issued with room available.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= dat_sm;
            mem_sof[wr_ptr]  <= (idx == '0);
        end
    end

endmodule

// File: tb/tb_wshb_frame_reader.sv
module tb_wshb_frame_reader;

    localparam int          HD   = 4;
    localparam int          VD   = 2;
    localparam int          NPIX = HD * VD;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          FD   = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] adr, dat_sm, dat_ms;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;
    logic [31:0] pix_data;
    logic        pix_sof, pix_valid, pix_ready, frame_done;

    // input sources: random during the reset check, slave model otherwise
    logic        rphase;
    logic        r_ack, r_err, r_rty, s_ack, s_err, s_rty;
    logic [31:0] r_dat, s_dat;
    assign ack    = rphase ? r_ack : s_ack;
    assign err    = rphase ? r_err : s_err;
    assign rty    = rphase ? r_rty : s_rty;
    assign dat_sm = rphase ? r_dat : s_dat;

    wshb_frame_reader #(.HDISP(HD), .VDISP(VD), .BASE_ADDR(BASE), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .adr(adr), .dat_sm(dat_sm), .dat_ms(dat_ms), .cyc(cyc), .stb(stb),
        .we(we), .sel(sel), .cti(cti), .bte(bte),
        .ack(ack), .err(err), .rty(rty),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: the frame memory, the pixel index that the next
    // successful read must hit, and the expected output stream
    logic [31:0] ram [NPIX];
    int          exp_idx   = 0;
    int          n_acks    = 0;
    logic [32:0] exq [$];
    bit          fd_exp    = 0;
    bit          err_armed = 0;
    bit          rty_rand  = 0;
    bit          rand_lat  = 0;
    int          lat       = 12;

    // Wishbone slave with configurable latency and error injection
    initial begin : slave
        int          wait_cnt;
        bit          term_prev;
        int          retry_chk;
        logic [31:0] retry_adr;
        int          w;
        int          a;
        wait_cnt = 0; term_prev = 0; retry_chk = 0; retry_adr = '0;
        s_ack = 0; s_err = 0; s_rty = 0; s_dat = '0;
        forever begin
            @(posedge clk); #1;
            s_ack = 0; s_err = 0; s_rty = 0; fd_exp = 0;
            if (rst) begin
                wait_cnt = 0; term_prev = 0; retry_chk = 0;
                continue;
            end
            if (term_prev) check("stb_gap", {63'b0, stb}, 64'd0);
            term_prev = 0;
            if (retry_chk > 0) begin
                retry_chk--;
                if (retry_chk == 0) begin
                    check("retry_stb", {63'b0, stb}, 64'd1);
                    check("retry_adr", {32'b0, adr}, {32'b0, retry_adr});
                end
            end
            if (stb) begin
                if (wait_cnt >= lat) begin
                    wait_cnt  = 0;
                    term_prev = 1;
                    check("adr", {32'b0, adr}, {32'b0, BASE + 32'(4 * exp_idx)});
                    if (err_armed && adr == BASE + 32'h8) begin
                        s_err = 1; err_armed = 0; retry_chk = 2; retry_adr = adr;
                    end else if (rty_rand && $urandom_range(0, 9) == 0) begin
                        s_rty = 1; retry_chk = 2; retry_adr = adr;
                    end else begin
                        w = exp_idx;
                        a = int'((adr - BASE) >> 2) & (NPIX - 1);
                        s_ack = 1;
                        s_dat = ram[a];
                        exq.push_back({w == 0, ram[w]});
                        ram[w]  = $urandom;
                        fd_exp  = (w == NPIX - 1);
                        exp_idx = (w + 1) % NPIX;
                        n_acks++;
                    end
                    if (rand_lat) lat = $urandom_range(0, 3);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // output monitor: pops the scoreboard whenever the consumer takes a word
    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("frame_done", {63'b0, frame_done}, {63'b0, fd_exp});
                if (pix_valid && pix_ready) begin
                    if (exq.size() == 0) begin
                        check("unexpected_pixel", {31'b0, pix_sof, pix_data}, 64'hDEAD);
                    end else begin
                        e = exq.pop_front();
                        check("pixel", {31'b0, pix_sof, pix_data}, {31'b0, e});
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stb"},   {63'b0, stb},        64'd0);
        check({tag, "_cyc"},   {63'b0, cyc},        64'd0);
        check({tag, "_valid"}, {63'b0, pix_valid},  64'd0);
        check({tag, "_sof"},   {63'b0, pix_sof},    64'd0);
        check({tag, "_fdone"}, {63'b0, frame_done}, 64'd0);
        check({tag, "_adr"},   {32'b0, adr},        {32'b0, BASE});
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int n0;
        int t;
        bit ok;
        for (int i = 0; i < NPIX; i++) ram[i] = $urandom;
        rphase = 1; rst = 0; enable = 0; pix_ready = 0;
        r_ack = 0; r_err = 0; r_rty = 0; r_dat = '0;

        // reset with random inputs, checked before the first clock edge
        #1 rst = 1;
        enable = 1'($urandom); pix_ready = 1'($urandom);
        r_ack = 1'($urandom); r_err = 1'($urandom); r_rty = 1'($urandom); r_dat = $urandom;
        #1 check_reset_outputs("rst0");
        for (int i = 0; i < 3; i++) begin
            tick();
            enable = 1'($urandom); pix_ready = 1'($urandom);
            r_ack = 1'($urandom); r_err = 1'($urandom); r_rty = 1'($urandom); r_dat = $urandom;
            @(negedge clk);
            check_reset_outputs("rstc");
        end

        // full frame plus wrap at latency 12, one error on the 3rd access
        tick();
        rphase = 0; enable = 1; pix_ready = 1; lat = 12; err_armed = 1;
        rst = 0;
        t = 0;
        while (n_acks < NPIX + 2 && t < 3000) begin tick(); t++; end
        check("frame_run_timeout", {63'b0, t >= 3000}, 64'd0);
        check("err_consumed", {63'b0, err_armed}, 64'd0);

        // reset mid-request: stb must fall without a clock edge
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin tick(); if (stb) ok = 1; end
        check("stb_before_rst", {63'b0, ok}, 64'd1);
        repeat (3) tick();
        @(negedge clk);
        rst = 1;
        #1;
        check_reset_outputs("rstmid");
        exq.delete();
        exp_idx = 0;
        n0 = n_acks;
        pix_ready = 0; lat = 2;
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        check("post_rst_empty", {63'b0, pix_valid}, 64'd0);
        check("post_rst_no_ack", 64'(n_acks - n0), 64'd0);

        // back-pressure: exactly FD reads, then a single pop frees one slot
        repeat (80) tick();
        @(negedge clk);
        check("bp_acks", 64'(n_acks - n0), 64'(FD));
        check("bp_stb_idle", {63'b0, stb}, 64'd0);
        check("bp_valid", {63'b0, pix_valid}, 64'd1);
        tick(); pix_ready = 1;
        tick(); pix_ready = 0;
        repeat (40) tick();
        @(negedge clk);
        check("bp_one_more", 64'(n_acks - n0), 64'(FD + 1));
        check("bp_stb_idle2", {63'b0, stb}, 64'd0);

        // drain, then drop enable while the read at idx 5 is outstanding
        tick(); pix_ready = 1; lat = 12;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            if (stb && adr == BASE + 32'h14) ok = 1;
        end
        check("idx5_req_seen", {63'b0, ok}, 64'd1);
        enable = 0;
        n0 = n_acks;
        t = 0;
        while (n_acks == n0 && t < 100) begin tick(); t++; end
        check("idx5_ack_done", 64'(n_acks - n0), 64'd1);
        repeat (30) tick();
        @(negedge clk);
        check("disabled_stb", {63'b0, stb}, 64'd0);
        check("disabled_no_ack", 64'(n_acks - n0), 64'd1);
        tick(); enable = 1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); if (stb) ok = 1; end
        check("resume_stb", {63'b0, ok}, 64'd1);
        check("resume_adr", {32'b0, adr}, {32'b0, BASE + 32'h18});

        // random latency, retries, errors and consumer stalls
        rand_lat = 1; rty_rand = 1; err_armed = 1;
        n0 = n_acks; t = 0;
        while (n_acks < n0 + 40 && t < 5000) begin
            tick();
            pix_ready = 1'($urandom);
            t++;
        end
        check("random_run_timeout", {63'b0, t >= 5000}, 64'd0);
        pix_ready = 1; enable = 0;
        repeat (40) tick();
        @(negedge clk);
        check("final_queue_empty", 64'(exq.size()), 64'd0);
        check("final_valid", {63'b0, pix_valid}, 64'd0);
        check("final_stb", {63'b0, stb}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
